main_func_mul_arb: RTL

MAIN_FUNC_MUL_ARB -- requirements
Module: main_func_mul_arb

---
 rtl/main_func_mul_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/main_func_mul_arb.sv
// Round-robin arbiter sharing one external combinational multiplier among NREQ requesters.
// Define MAIN_FUNC_MUL_ARB_PIPE_EN to add a registered operand stage (latency 2 instead of 1).
module main_func_mul_arb #(
  parameter int NREQ    = 4,
  parameter int A_WIDTH = 6,
  parameter int B_WIDTH = 8,
  parameter int P_WIDTH = 13
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*A_WIDTH-1:0]    req_a,
  input  logic [NREQ*B_WIDTH-1:0]    req_b,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [P_WIDTH-1:0]         rsp_p,
  output logic                       mul_busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} res_state_t;

  res_state_t           state, state_nxt;
  logic [IDW-1:0]       last_grant;
  logic [IDW-1:0]       win_idx;
  logic                 win_any;
  logic [A_WIDTH-1:0]   win_a;
  logic [B_WIDTH-1:0]   win_b;
  logic                 res_adv;
  logic                 issue;
  logic                 capture;
  logic [IDW-1:0]       cap_id;
  int unsigned          cand;

  // Search order starts one past the last accepted requester.
  always_comb begin
    win_any = 1'b0;
    win_idx = last_grant;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last_grant) + k) % NREQ;
      if (!win_any && req_valid[cand[IDW-1:0]]) begin
        win_any = 1'b1;
        win_idx = cand[IDW-1:0];
      end
    end
  end

  assign win_a   = req_a[win_idx*A_WIDTH +: A_WIDTH];
  assign win_b   = req_b[win_idx*B_WIDTH +: B_WIDTH];
  assign res_adv = (state == EMPTY) || rsp_ready;

`ifdef MAIN_FUNC_MUL_ARB_PIPE_EN
  logic               op_valid;
  logic [A_WIDTH-1:0] op_a;
  logic [B_WIDTH-1:0] op_b;
  logic [IDW-1:0]     op_id;
  logic               op_adv;

  assign op_adv  = !op_valid || res_adv;
  assign issue   = win_any && op_adv;
  assign capture = op_valid && res_adv;
  assign cap_id  = op_id;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_id    <= '0;
    end else if (op_adv) begin
      op_valid <= win_any;
      if (win_any) begin
        op_a  <= win_a;
        op_b  <= win_b;
        op_id <= win_idx;
      end
    end
  end

  assign mul_din0 = op_valid ? op_a : '0;
  assign mul_din1 = op_valid ? op_b : '0;
  assign mul_busy = rsp_valid || op_valid;
`else
  assign issue    = win_any && res_adv;
  assign capture  = issue;
  assign cap_id   = win_idx;
  assign mul_din0 = win_any ? win_a : '0;
  assign mul_din1 = win_any ? win_b : '0;
  assign mul_busy = rsp_valid;
`endif

  always_comb begin
    req_ready = '0;
    if (ap_rst_n && issue) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= EMPTY;
      last_grant <= IDW'(NREQ - 1);
      rsp_p      <= '0;
      rsp_id     <= '0;
    end else begin
      state <= state_nxt;
      if (issue) last_grant <= win_idx;
      if (capture) begin
        rsp_p  <= mul_dout;
        rsp_id <= cap_id;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = (state == FULL);
    case (state)
      EMPTY:   if (capture) state_nxt = FULL;
      FULL:    if (rsp_ready && !capture) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

endmodule
